// File: rtl/mux_nx1_stream_arb.sv
// N-to-1 registered stream mux with packet-locked arbitration (fixed priority or
// round-robin). Selection is held from the first beat of a packet until its last beat.
module mux_nx1_stream_arb #(
   parameter int NUM_IN   = 4,
   parameter int DATA_W   = 32,
   parameter int ARB_MODE = 1,
   parameter int SRC_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic                     enable,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   input  logic [NUM_IN-1:0]        in_last,
   input  logic [NUM_IN-1:0]        in_valid,
   output logic [NUM_IN-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   output logic [SRC_W-1:0]         out_src,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy
);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   lock_q, lock_d;
   logic [SRC_W-1:0]   rr_q, rr_d;
   logic [DATA_W-1:0]  data_q;
   logic               last_q;
   logic [SRC_W-1:0]   src_q;
   logic               valid_q;

   logic [DATA_W-1:0]  ch_data [NUM_IN];
   logic [SRC_W-1:0]   g;
   logic [SRC_W-1:0]   g_lo, g_hi;
   logic               hit_any, hit_hi;
   logic               slot_free, rdy, accept;

   for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
      assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
   end

   // Lowest valid index overall and lowest valid index at/after rr_q; round-robin
   // prefers the latter and wraps to the former.
   always_comb begin
      g_lo    = '0;
      g_hi    = '0;
      hit_any = 1'b0;
      hit_hi  = 1'b0;
      for (int j = NUM_IN - 1; j >= 0; j--) begin
         if (in_valid[j]) begin
            g_lo    = SRC_W'(j);
            hit_any = 1'b1;
            if (SRC_W'(j) >= rr_q) begin
               g_hi   = SRC_W'(j);
               hit_hi = 1'b1;
            end
         end
      end
   end

   always_comb begin
      g = lock_q;
      if (state_q == S_IDLE) begin
         if (ARB_MODE == 1 && hit_hi) g = g_hi;
         else                         g = g_lo;
      end
   end

   assign slot_free = !valid_q || out_ready;
   assign rdy       = !ARESET && enable && slot_free && ((state_q == S_LOCKED) || hit_any);
   assign accept    = rdy && in_valid[g];

   always_comb begin
      in_ready = '0;
      if (rdy) in_ready[g] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      rr_d    = rr_q;
      if (accept) begin
         if (in_last[g]) begin
            state_d = S_IDLE;
            rr_d    = (g == SRC_W'(NUM_IN - 1)) ? '0 : g + 1'b1;
         end else begin
            state_d = S_LOCKED;
            lock_d  = g;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= S_IDLE;
         lock_q  <= '0;
         rr_q    <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         src_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         rr_q    <= rr_d;
         if (accept) begin
            data_q  <= ch_data[g];
            last_q  <= in_last[g];
            src_q   <= g;
            valid_q <= 1'b1;
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign out_data  = data_q;
   assign out_last  = last_q;
   assign out_src   = src_q;
   assign out_valid = valid_q;
   assign busy      = (state_q == S_LOCKED);

endmodule

// File: tb/tb_mux_nx1_stream_arb.sv
// Directed bench: a fixed-priority instance (u0) and a round-robin instance (u1)
// share the same stimulus; each scenario checks the instance it targets.
module tb_mux_nx1_stream_arb;
   localparam int N  = 4;
   localparam int DW = 8;

   logic          ACLK = 1'b0;
   logic          ARESET, enable, out_ready;
   logic [N-1:0]  in_valid, in_last;
   logic [DW-1:0] dat [N];
   logic [N*DW-1:0] in_data;

   logic [N-1:0]  rdy0, rdy1;
   logic [DW-1:0] od0, od1;
   logic          ol0, ol1, ov0, ov1, bz0, bz1;
   logic [1:0]    os0, os1;

   int nvec = 0;
   int nerr = 0;

   assign in_data = {dat[3], dat[2], dat[1], dat[0]};

   always #5 ACLK = ~ACLK;

   mux_nx1_stream_arb #(.NUM_IN(N), .DATA_W(DW), .ARB_MODE(0)) u0 (
      .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .in_data(in_data),
      .in_last(in_last), .in_valid(in_valid), .in_ready(rdy0), .out_data(od0),
      .out_last(ol0), .out_src(os0), .out_valid(ov0), .out_ready(out_ready), .busy(bz0));

   mux_nx1_stream_arb #(.NUM_IN(N), .DATA_W(DW), .ARB_MODE(1)) u1 (
      .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .in_data(in_data),
      .in_last(in_last), .in_valid(in_valid), .in_ready(rdy1), .out_data(od1),
      .out_last(ol1), .out_src(os1), .out_valid(ov1), .out_ready(out_ready), .busy(bz1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then changed and
   // checks are made #1 later, well away from either edge.
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      ARESET   = 1'b1;
      in_valid = '0;
      tick();
      ARESET   = 1'b0;
   endtask

   initial begin
      ARESET = 1'b1; enable = 1'b1; out_ready = 1'b1;
      in_valid = '0; in_last = '0;
      for (int i = 0; i < N; i++) dat[i] = '0;
      tick(); tick();

      // reset: outputs at reset values, in_ready held low while ARESET=1
      in_valid = 4'b1111;
      #1;
      chk("rst_rdy0", rdy0, 0);
      chk("rst_rdy1", rdy1, 0);
      chk("rst_ov", ov1, 0);
      chk("rst_busy", bz1, 0);
      chk("rst_src", os1, 0);
      chk("rst_data", od1, 0);
      chk("rst_last", ol1, 0);
      in_valid = '0;
      ARESET = 1'b0;
      tick();

      // fixed priority: ch1 always beats ch3
      dat[1] = 8'h11; dat[3] = 8'h33; in_last = 4'b1111; in_valid = 4'b1010;
      #1;
      chk("fp_rdy_first", rdy0, 4'b0010);
      chk("fp_ov_before", ov0, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("fp_ov", ov0, 1);
         chk("fp_data", od0, 8'h11);
         chk("fp_src", os0, 1);
         chk("fp_rdy", rdy0, 4'b0010);
      end
      in_valid = 4'b1000;
      #1;
      chk("fp_rdy_ch3", rdy0, 4'b1000);
      tick();
      chk("fp_data_ch3", od0, 8'h33);
      chk("fp_src_ch3", os0, 3);

      // round-robin: 0,1,2,3,0,... back-to-back
      do_reset();
      for (int i = 0; i < N; i++) dat[i] = 8'(8'h40 + i);
      in_last = 4'b1111; in_valid = 4'b1111;
      #1;
      chk("rr_rdy0", rdy1, 4'b0001);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_ov", ov1, 1);
         chk("rr_src", os1, k % 4);
         chk("rr_data", od1, 8'h40 + (k % 4));
      end

      // packet lock: 3-beat ch2 packet holds off a valid ch0
      do_reset();
      in_valid = 4'b0100; dat[2] = 8'hA1; in_last = 4'b0000;
      #1;
      chk("lk_rdy_b1", rdy1, 4'b0100);
      tick();
      chk("lk_d1", od1, 8'hA1);
      chk("lk_busy1", bz1, 1);
      in_valid = 4'b0101; dat[2] = 8'hA2; dat[0] = 8'h05; in_last = 4'b0001;
      #1;
      chk("lk_rdy_b2", rdy1, 4'b0100);
      tick();
      chk("lk_d2", od1, 8'hA2);
      chk("lk_s2", os1, 2);
      chk("lk_busy2", bz1, 1);
      dat[2] = 8'hA3; in_last = 4'b0101;
      #1;
      chk("lk_rdy_b3", rdy1, 4'b0100);
      tick();
      chk("lk_d3", od1, 8'hA3);
      chk("lk_s3", os1, 2);
      chk("lk_l3", ol1, 1);
      chk("lk_busy3", bz1, 0);
      in_valid = 4'b0001;
      #1;
      chk("lk_rdy_ch0", rdy1, 4'b0001);
      tick();
      chk("lk_d_ch0", od1, 8'h05);
      chk("lk_s_ch0", os1, 0);

      // backpressure: 4 stalled cycles in the middle of a ch1 packet
      do_reset();
      in_valid = 4'b0010; in_last = 4'b0000; dat[1] = 8'hB1;
      tick();
      chk("bp_d1", od1, 8'hB1);
      dat[1] = 8'hB2;
      tick();
      chk("bp_d2", od1, 8'hB2);
      dat[1] = 8'hB3; out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("bp_hold_d", od1, 8'hB2);
         chk("bp_hold_v", ov1, 1);
         chk("bp_hold_s", os1, 1);
         chk("bp_hold_rdy", rdy1, 0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_still_d", od1, 8'hB2);
      chk("bp_resume_rdy", rdy1, 4'b0010);
      tick();
      chk("bp_d3", od1, 8'hB3);
      dat[1] = 8'hB4; in_last = 4'b0010;
      tick();
      chk("bp_d4", od1, 8'hB4);
      chk("bp_l4", ol1, 1);
      chk("bp_busy4", bz1, 0);
      in_valid = '0;
      tick();
      chk("bp_drained", ov1, 0);

      // enable gating mid-packet: ch1 finishes before ch0 gets in
      do_reset();
      in_valid = 4'b0010; in_last = 4'b0000; dat[1] = 8'hC1;
      tick();
      chk("en_d1", od1, 8'hC1);
      enable = 1'b0; in_valid = 4'b0011; dat[1] = 8'hC2; dat[0] = 8'h0D; in_last = 4'b0011;
      #1;
      chk("en_rdy_off0", rdy1, 0);
      tick();
      chk("en_drain", ov1, 0);
      chk("en_busy", bz1, 1);
      chk("en_rdy_off1", rdy1, 0);
      tick();
      chk("en_rdy_off2", rdy1, 0);
      enable = 1'b1;
      #1;
      chk("en_rdy_on", rdy1, 4'b0010);
      tick();
      chk("en_d2", od1, 8'hC2);
      chk("en_s2", os1, 1);
      in_valid = 4'b0001;
      tick();
      chk("en_d_ch0", od1, 8'h0D);
      chk("en_s_ch0", os1, 0);

      // reset while locked on ch3: lock dropped, ch0 granted first afterwards
      do_reset();
      in_valid = 4'b1000; in_last = 4'b0000; dat[3] = 8'hD1;
      tick();
      chk("rm_busy", bz1, 1);
      chk("rm_s", os1, 3);
      ARESET = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; dat[0] = 8'hE0;
      #1;
      chk("rm_rdy_in_rst", rdy1, 0);
      tick();
      chk("rm_ov", ov1, 0);
      chk("rm_busy0", bz1, 0);
      ARESET = 1'b0;
      #1;
      chk("rm_rdy_ch0", rdy1, 4'b0001);
      tick();
      chk("rm_s0", os1, 0);
      chk("rm_d0", od1, 8'hE0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
